// File: rtl/download_fifo.sv
// download_fifo: elastic write buffer between the HPS download channel and the
// machine's download port. Bytes are queued with their 17-bit target address
// and drained into RAM one at a time whenever the RAM port grants a slot.
// The HPS is throttled through ioctl_wait, and dn_go frames the whole transfer.
module download_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WR_GAP = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        dn_ready,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [23:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // The gap counter needs at least one bit even when WR_GAP is 0
    localparam int unsigned GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    // Raise backpressure two entries early: one HPS write may already be in flight
    localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 2);
    localparam logic [GW-1:0] GAP_LOAD = GW'(WR_GAP);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_TAIL  = 2'd3;

    // Entry layout: {sel, ioctl_addr[15:0], data[7:0]}
    logic [24:0]   mem [DEPTH];
    logic [24:0]   head;
    logic [24:0]   new_entry;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    state_q, state_d;
    logic          dl_q;

    logic          wait_q;
    logic          go_q;
    logic          wr_q;
    logic [23:0]   addr_q;
    logic [7:0]    data_q;
    logic          ovf_q, ovf_d;

    logic          idx_ok;
    logic          dl_rise;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;

    // Push/pop decisions, occupancy, pacing and sticky overflow
    always_comb begin
        idx_ok    = (ioctl_index[7:1] == 7'd0);
        dl_rise   = ioctl_download && !dl_q && idx_ok;
        push_req  = ioctl_wr && ioctl_download && idx_ok;
        // A pop only ever consumes an entry that existed before this cycle
        pop       = (count_q != '0) && dn_ready && (gap_q == '0);
        // At full, a same-cycle pop frees the slot the push needs
        push      = push_req && ((count_q < FULL_LVL) || pop);
        drop      = push_req && !push;
        new_entry = {ioctl_index[0], ioctl_addr, ioctl_dout};
        head      = mem[rd_ptr_q];

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        gap_d = gap_q;
        if (pop) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end

        // A drop in the same cycle as a new download start still sets the flag
        ovf_d = ovf_q;
        if (dl_rise) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Transfer framing: IDLE -> FILL -> DRAIN -> TAIL -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dl_rise) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!ioctl_download) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A restarted download keeps whatever is still queued
                if (dl_rise) begin
                    state_d = ST_FILL;
                end else if ((count_q == '0) && !pop) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (dl_rise) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage array; no reset needed since occupancy is tracked separately
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            dl_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            wait_q   <= 1'b0;
            go_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dl_q     <= ioctl_download;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            wait_q   <= (count_d >= WAIT_LVL);
            go_q     <= (state_d != ST_IDLE);
            wr_q     <= pop;
            ovf_q    <= ovf_d;
            // Address/data hold their last value between strobes
            if (pop) begin
                addr_q <= {7'b0, head[24:8]};
                data_q <= head[7:0];
            end
        end
    end

    assign ioctl_wait = wait_q;
    assign dn_go      = go_q;
    assign dn_wr      = wr_q;
    assign dn_addr    = addr_q;
    assign dn_data    = data_q;
    assign overflow   = ovf_q;

    // Occupancy never exceeds the array size
    a_count_bound: assert property (@(posedge clk_sys) disable iff (!reset_n)
        count_q <= FULL_LVL);

    // With a nonzero gap, write strobes are never adjacent
    if (WR_GAP > 0) begin : g_gap_check
        a_wr_spacing: assert property (@(posedge clk_sys) disable iff (!reset_n)
            wr_q |=> !wr_q);
    end

endmodule

// File: tb/tb_download_fifo.sv
// Bench for download_fifo: directed scenarios plus a randomized stream checked
// against a queue-based reference model and an in-order scoreboard.
module tb_download_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned WR_GAP = 1;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        dn_ready;
    logic        dn_go;
    logic        dn_wr;
    logic [23:0] dn_addr;
    logic [7:0]  dn_data;
    logic        overflow;

    download_fifo #(
        .DEPTH  (DEPTH),
        .WR_GAP (WR_GAP)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dn_ready       (dn_ready),
        .dn_go          (dn_go),
        .dn_wr          (dn_wr),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .overflow       (overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int total;
    int bad;

    // Reference model: queued entries plus the pacing rule, evaluated per edge
    logic [24:0] m_q [$];
    int          m_gap;
    logic        m_wr;
    logic [23:0] m_addr;
    logic [7:0]  m_data;
    logic        m_ovf;
    logic        m_prev_dl;
    logic        m_wait;

    task automatic model_clear();
        m_q.delete();
        m_gap     = 0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_ovf     = 1'b0;
        m_prev_dl = 1'b0;
        m_wait    = 1'b0;
    endtask

    // Advance one clock, update the model with the inputs seen at that edge
    task automatic tick();
        logic [24:0] e;
        bit acc, pop, push_req, push;
        @(posedge clk_sys);
        if (!reset_n) begin
            model_clear();
        end else begin
            acc      = (ioctl_index <= 8'd1);
            pop      = (m_q.size() > 0) && dn_ready && (m_gap == 0);
            push_req = ioctl_wr && ioctl_download && acc;
            push     = push_req && ((m_q.size() < DEPTH) || pop);
            if (pop) begin
                e      = m_q.pop_front();
                m_wr   = 1'b1;
                m_addr = {7'b0, e[24:8]};
                m_data = e[7:0];
            end else begin
                m_wr = 1'b0;
            end
            m_gap = pop ? WR_GAP : ((m_gap > 0) ? m_gap - 1 : 0);
            if (push) m_q.push_back({ioctl_index[0], ioctl_addr, ioctl_dout});
            if (ioctl_download && !m_prev_dl && acc) m_ovf = 1'b0;
            if (push_req && !push) m_ovf = 1'b1;
            m_prev_dl = ioctl_download;
            m_wait    = (m_q.size() >= DEPTH - 2);
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        dn_ready       = 1'b0;
        model_clear();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        dn_ready       = 1'b0;
        model_clear();
        tick();
        tick();
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL reset ioctl_wait: got %b want 0", ioctl_wait); end
        total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL reset dn_go: got %b want 0", dn_go); end
        total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL reset dn_wr: got %b want 0", dn_wr); end
        total++; if (dn_addr !== 24'h0) begin bad++; $display("FAIL reset dn_addr: got %h want 000000", dn_addr); end
        total++; if (dn_data !== 8'h0) begin bad++; $display("FAIL reset dn_data: got %h want 00", dn_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_byte(input string tag);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        dn_ready       = 1'b0;
        tick();
        total++; if (dn_go !== 1'b1) begin bad++; $display("FAIL %s go_rise: got %b want 1", tag, dn_go); end
        ioctl_wr   = 1'b1;
        ioctl_addr = 16'h0005;
        ioctl_dout = 8'hA5;
        tick();
        total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL %s early_wr: got %b want 0", tag, dn_wr); end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        dn_ready       = 1'b1;
        tick();
        total++; if (dn_wr !== 1'b1) begin bad++; $display("FAIL %s wr_n2: got %b want 1", tag, dn_wr); end
        total++; if (dn_addr !== 24'h010005) begin bad++; $display("FAIL %s addr: got %h want 010005", tag, dn_addr); end
        total++; if (dn_data !== 8'hA5) begin bad++; $display("FAIL %s data: got %h want a5", tag, dn_data); end
        tick();
        total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL %s wr_one_cycle: got %b want 0", tag, dn_wr); end
        total++; if (dn_go !== 1'b1) begin bad++; $display("FAIL %s go_tail: got %b want 1", tag, dn_go); end
        total++; if (dn_addr !== 24'h010005) begin bad++; $display("FAIL %s addr_hold: got %h want 010005", tag, dn_addr); end
        tick();
        total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL %s go_fall: got %b want 0", tag, dn_go); end
        dn_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        dn_ready       = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 16'(i);
            ioctl_dout = 8'($urandom);
            tick();
            if (i == 12) begin
                total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL stall wait_at13: got %b want 0", ioctl_wait); end
            end
            if (i == 13) begin
                total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL stall wait_at14: got %b want 1", ioctl_wait); end
            end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stall ovf_at16: got %b want 0", overflow); end
        total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL stall wait_at16: got %b want 1", ioctl_wait); end
        ioctl_addr = 16'd16;
        ioctl_dout = 8'h5A;
        tick();
        ioctl_wr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL stall ovf_at17: got %b want 1", overflow); end
    endtask

    task automatic test_release();
        int nwr;
        int prev;
        nwr  = 0;
        prev = -1;
        dn_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            total++; if (dn_wr !== m_wr) begin bad++; $display("FAIL release dn_wr c=%0d: got %b want %b", c, dn_wr, m_wr); end
            total++; if (ioctl_wait !== m_wait) begin bad++; $display("FAIL release wait c=%0d: got %b want %b", c, ioctl_wait, m_wait); end
            if (dn_wr === 1'b1) begin
                total++; if (dn_addr !== 24'(nwr)) begin bad++; $display("FAIL release order: got %h want %h", dn_addr, 24'(nwr)); end
                if (prev >= 0) begin
                    total++; if (c - prev !== WR_GAP + 1) begin bad++; $display("FAIL release spacing: got %0d want %0d", c - prev, WR_GAP + 1); end
                end
                nwr++;
                prev = c;
                // Count drops to 14 after the 2nd write and to 13 after the 3rd
                if (nwr == 2) begin
                    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL release wait_c14: got %b want 1", ioctl_wait); end
                end
                if (nwr == 3) begin
                    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL release wait_c13: got %b want 0", ioctl_wait); end
                end
            end
        end
        total++; if (nwr !== 16) begin bad++; $display("FAIL release count: got %0d want 16", nwr); end
        ioctl_download = 1'b0;
        for (int c = 0; c < 10 && dn_go !== 1'b0; c++) tick();
        total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL release go_end: got %b want 0", dn_go); end
    endtask

    task automatic test_wrap();
        logic [24:0] sent [$];
        logic [24:0] exp_e;
        logic [7:0]  idx;
        int np;
        int nw;
        np  = 0;
        nw  = 0;
        idx = 8'($urandom_range(0, 1));
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        // New download start clears the overflow left over from the stall test
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap ovf_clear: got %b want 0", overflow); end
        for (int c = 0; c < 180; c++) begin
            dn_ready = (c % 2 == 0);
            if ((c % 3 == 0) && (np < 40)) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 16'($urandom);
                ioctl_dout = 8'($urandom);
                sent.push_back({idx[0], ioctl_addr, ioctl_dout});
                np++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            total++; if (dn_wr !== m_wr) begin bad++; $display("FAIL wrap dn_wr c=%0d: got %b want %b", c, dn_wr, m_wr); end
            total++; if (ioctl_wait !== m_wait) begin bad++; $display("FAIL wrap wait c=%0d: got %b want %b", c, ioctl_wait, m_wait); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap ovf c=%0d: got %b want 0", c, overflow); end
            if (dn_wr === 1'b1) begin
                if (sent.size() == 0) begin
                    total++; bad++; $display("FAIL wrap extra_wr: got write %h want none", dn_addr);
                end else begin
                    exp_e = sent.pop_front();
                    total++; if (dn_addr !== {7'b0, exp_e[24:8]}) begin bad++; $display("FAIL wrap addr #%0d: got %h want %h", nw, dn_addr, {7'b0, exp_e[24:8]}); end
                    total++; if (dn_data !== exp_e[7:0]) begin bad++; $display("FAIL wrap data #%0d: got %h want %h", nw, dn_data, exp_e[7:0]); end
                end
                nw++;
            end
        end
        ioctl_wr = 1'b0;
        total++; if (nw !== 40) begin bad++; $display("FAIL wrap count: got %0d want 40", nw); end
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL wrap wait_end: got %b want 0", ioctl_wait); end
        ioctl_download = 1'b0;
        for (int c = 0; c < 10 && dn_go !== 1'b0; c++) tick();
        total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL wrap go_end: got %b want 0", dn_go); end
        dn_ready = 1'b0;
    endtask

    task automatic test_filter();
        do_reset();
        ioctl_index    = 8'd2;
        ioctl_download = 1'b1;
        dn_ready       = 1'b1;
        for (int c = 0; c < 16; c++) begin
            ioctl_wr   = (c % 2 == 0);
            ioctl_addr = 16'(c);
            ioctl_dout = 8'($urandom);
            tick();
            total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL filter dn_wr c=%0d: got %b want 0", c, dn_wr); end
            total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL filter dn_go c=%0d: got %b want 0", c, dn_go); end
            total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL filter wait c=%0d: got %b want 0", c, ioctl_wait); end
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        dn_ready       = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        dn_ready       = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 16'(16'h0100 + i);
            ioctl_dout = 8'($urandom);
            tick();
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        dn_ready = 1'b1;
        tick();
        total++; if (dn_wr !== 1'b1) begin bad++; $display("FAIL midrst pre_wr: got %b want 1", dn_wr); end
        // Asynchronous reset between clock edges
        reset_n = 1'b0;
        model_clear();
        #1;
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL midrst ioctl_wait: got %b want 0", ioctl_wait); end
        total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL midrst dn_go: got %b want 0", dn_go); end
        total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL midrst dn_wr: got %b want 0", dn_wr); end
        total++; if (dn_addr !== 24'h0) begin bad++; $display("FAIL midrst dn_addr: got %h want 000000", dn_addr); end
        total++; if (dn_data !== 8'h0) begin bad++; $display("FAIL midrst dn_data: got %h want 00", dn_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst overflow: got %b want 0", overflow); end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL midrst stale_wr c=%0d: got %b want 0", c, dn_wr); end
            total++; if (dn_go !== 1'b0) begin bad++; $display("FAIL midrst stale_go c=%0d: got %b want 0", c, dn_go); end
        end
        dn_ready = 1'b0;
        test_single_byte("after_rst");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_byte("single");
        test_stall();
        test_release();
        test_wrap();
        test_filter();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
